// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: SPI pins plus the register-side write/read strobes.
// slave modport is the responder; master modport is the far-end driver.
interface spi_slave_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    input  rd_data,
    output miso,
    output miso_oe,
    output wr_data,
    output wr_valid,
    output rd_req,
    output frame_err
  );

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    output rd_data,
    input  miso,
    input  miso_oe,
    input  wr_data,
    input  wr_valid,
    input  rd_req,
    input  frame_err
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI mode-0 responder, one command byte then one data byte.
// Define SPI_SLAVE_PARITY_EN to add an odd-parity 9th bit to the data phase.
module spi_slave_ctrl #(
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] WR_CMD = DATA_W'(8'hAD),
  parameter logic [DATA_W-1:0] RD_CMD = DATA_W'(8'h2D)
) (
  input logic             m_clk,
  input logic             n_reset,
  spi_slave_ctrl_if.slave bus
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LOAD,
    S_WR,
    S_RD,
    S_SKIP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       cs_prev_q, cs_prev_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sin_q, sin_d;
  logic [DATA_W-1:0] sout_q, sout_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;

`ifdef SPI_SLAVE_PARITY_EN
  logic par_ph_q, par_ph_d;
  logic rd_par_q, rd_par_d;
  logic par_fail;
`endif

  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_hi;
  logic              cs_fall;
  logic              mosi_s;
  logic              bit_last;
  logic              cmd_done;
  logic              rd_shift;
  logic              sout_fill;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] sin_shift;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_hi     = cs_sync_q[1];
  assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;
  assign mosi_s    = mosi_sync_q[1];
  assign bit_last  = (cnt_q == LAST);
  assign cnt_nxt   = bit_last ? '0 : cnt_q + 1'b1;
  assign sin_shift = {sin_q[DATA_W-2:0], mosi_s};
  assign cmd_done  = (state_q == S_CMD) & ~cs_hi
                   & sclk_rise & bit_last;

`ifdef SPI_SLAVE_PARITY_EN
  assign sout_fill = rd_par_q;
  // Hold off until a data rise: the fall ending the command must not shift.
  assign rd_shift  = sclk_fall & ((cnt_q != '0) | par_ph_q);
  assign par_fail  = (state_q == S_WR) & par_ph_q & ~cs_hi
                   & sclk_rise & (mosi_s == ^sin_q);
`else
  assign sout_fill = 1'b0;
  assign rd_shift  = sclk_fall & (cnt_q != '0);
`endif

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      sin_q       <= '0;
      sout_q      <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      par_ph_q    <= 1'b0;
      rd_par_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      cnt_q       <= cnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
`ifdef SPI_SLAVE_PARITY_EN
      par_ph_q    <= par_ph_d;
      rd_par_q    <= rd_par_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[0], bus.sclk};
    cs_sync_d   = {cs_sync_q[0], bus.cs_n};
    mosi_sync_d = {mosi_sync_q[0], bus.mosi};
    sclk_prev_d = sclk_sync_q[1];
    cs_prev_d   = cs_sync_q[1];
    cnt_d       = cnt_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
    par_ph_d    = par_ph_q;
    rd_par_d    = rd_par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
          sin_d   = '0;
`ifdef SPI_SLAVE_PARITY_EN
          par_ph_d = 1'b0;
`endif
        end
      end
      S_CMD: begin
        if (cs_hi) begin
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          sin_d = sin_shift;
          cnt_d = cnt_nxt;
          if (bit_last) begin
            if (sin_shift == WR_CMD)
              state_d = S_WR;
            else if (sin_shift == RD_CMD)
              state_d = S_LOAD;
            else
              state_d = S_SKIP;
          end
        end
      end
      S_LOAD: begin
        if (cs_hi) begin
          state_d = S_IDLE;
        end else begin
          sout_d  = bus.rd_data;
          state_d = S_RD;
`ifdef SPI_SLAVE_PARITY_EN
          rd_par_d = ~^bus.rd_data;
`endif
        end
      end
      S_WR: begin
        if (cs_hi) begin
          state_d = S_IDLE;
        end else if (sclk_rise) begin
`ifdef SPI_SLAVE_PARITY_EN
          if (par_ph_q) begin
            state_d  = S_DONE;
            par_ph_d = 1'b0;
            if (mosi_s != ^sin_q) begin
              wr_valid_d = 1'b1;
              wr_data_d  = sin_q;
            end
          end else begin
            sin_d = sin_shift;
            cnt_d = cnt_nxt;
            if (bit_last)
              par_ph_d = 1'b1;
          end
`else
          sin_d = sin_shift;
          cnt_d = cnt_nxt;
          if (bit_last) begin
            wr_valid_d = 1'b1;
            wr_data_d  = sin_shift;
            state_d    = S_DONE;
          end
`endif
        end
      end
      S_RD: begin
        if (cs_hi) begin
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          cnt_d = cnt_nxt;
`ifdef SPI_SLAVE_PARITY_EN
          if (par_ph_q)
            state_d = S_DONE;
          else if (bit_last)
            par_ph_d = 1'b1;
`else
          if (bit_last)
            state_d = S_DONE;
`endif
        end else if (rd_shift) begin
          sout_d = {sout_q[DATA_W-2:0], sout_fill};
        end
      end
      S_SKIP, S_DONE: begin
        if (cs_hi)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic short_frame;
  logic bad_cmd;

  always_comb begin
    short_frame = cs_hi & (state_q inside {S_CMD, S_LOAD, S_WR, S_RD});
    bad_cmd     = cmd_done & (sin_shift != WR_CMD)
                & (sin_shift != RD_CMD);
    bus.rd_req  = cmd_done & (sin_shift == RD_CMD);
`ifdef SPI_SLAVE_PARITY_EN
    bus.frame_err = short_frame | bad_cmd | par_fail;
`else
    bus.frame_err = short_frame | bad_cmd;
`endif
    bus.miso_oe  = ~cs_hi;
    bus.miso     = (state_q == S_RD) & sout_q[DATA_W-1];
    bus.wr_valid = wr_valid_q;
    bus.wr_data  = wr_data_q;
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: frame-level model of the SPI responder,
// directed frames from the test plan plus randomized frames.
module tb_spi_slave_ctrl;

  localparam logic [7:0] WR = 8'hAD;
  localparam logic [7:0] RD = 8'h2D;
  localparam int HALF = 6;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int DLEN = 9;
`else
  localparam int DLEN = 8;
`endif

  logic clk;
  logic n_reset;

  spi_slave_ctrl_if #(.DATA_W(8)) bus ();

  spi_slave_ctrl #(
    .DATA_W(8),
    .WR_CMD(8'hAD),
    .RD_CMD(8'h2D)
  ) dut (
    .m_clk  (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_wv = 0;
  int n_rr = 0;
  int n_fe = 0;
  int settle = 0;

  logic [2:0] hist;
  logic [7:0] exp_wr_data;
  logic [7:0] exp_wv_data;
  logic [7:0] rd_val;
  logic [7:0] rd_bits;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // cs_n pin history, used to predict the synchronized miso_oe
  always @(posedge clk) hist <= {hist[1:0], bus.cs_n};

  // Register side: rd_data valid only in the cycle after rd_req
  always @(posedge clk)
    bus.rd_data <= bus.rd_req ? rd_val : 8'($urandom);

  always @(negedge clk) begin
    if (!n_reset) begin
      settle = 0;
      chk("rst_miso", bus.miso, 0);
      chk("rst_miso_oe", bus.miso_oe, 0);
      chk("rst_wr_valid", bus.wr_valid, 0);
      chk("rst_rd_req", bus.rd_req, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_wr_data", bus.wr_data, 0);
    end else begin
      if (settle < 3)
        settle++;
      else
        chk("miso_oe", bus.miso_oe, {31'd0, ~hist[1]});
      if (bus.wr_valid) begin
        n_wv++;
        chk("wr_data_at_valid", bus.wr_data, exp_wv_data);
      end
      if (bus.rd_req) n_rr++;
      if (bus.frame_err) n_fe++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic spi_bit(input bit b, input bit em, input string nm,
                         output bit m);
    bus.mosi = b;
    tick(HALF);
    m = bus.miso;
    chk(nm, m, em);
    bus.sclk = 1'b1;
    tick(HALF);
    bus.sclk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input int ncmd,
                       input logic [7:0] data, input int ndata,
                       input bit pbit, input int extra,
                       input logic [7:0] rv);
    bit is_wr, is_rd, full, par_ok, b, em, m;
    int exp_wv, exp_rr, exp_fe, b_wv, b_rr, b_fe;
    is_wr  = (ncmd == 8) && (cmd == WR);
    is_rd  = (ncmd == 8) && (cmd == RD);
    full   = ndata >= DLEN;
    par_ok = (DLEN == 8) || (pbit == ~^data);
    exp_rr = int'(is_rd);
    exp_wv = int'(is_wr && full && par_ok);
    exp_fe = int'((ncmd < 8) || (ncmd == 8 && !is_wr && !is_rd)
                  || ((is_wr || is_rd) && !full)
                  || (is_wr && full && !par_ok));
    rd_val      = rv;
    exp_wv_data = data;
    rd_bits     = 8'h00;
    b_wv = n_wv;
    b_rr = n_rr;
    b_fe = n_fe;
    bus.cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < ncmd; i++)
      spi_bit(cmd[7-i], 1'b0, "miso_cmd", m);
    if (ncmd == 8) begin
      for (int i = 0; i < ndata; i++) begin
        b  = (i < 8) ? data[7-i] : pbit;
        em = 1'b0;
        if (is_rd) begin
          b  = 1'($urandom);
          em = (i < 8) ? rv[7-i] : ~^rv;
        end
        spi_bit(b, em, is_rd ? "miso_rd" : "miso_quiet", m);
        if (is_rd && i < 8) rd_bits = {rd_bits[6:0], m};
      end
      for (int i = 0; i < extra; i++)
        spi_bit(1'($urandom), 1'b0, "miso_done", m);
    end
    tick(4);
    bus.cs_n = 1'b1;
    tick(8);
    chk("wr_valid_count", n_wv - b_wv, exp_wv);
    chk("rd_req_count", n_rr - b_rr, exp_rr);
    chk("frame_err_count", n_fe - b_fe, exp_fe);
    if (exp_wv != 0) exp_wr_data = data;
    chk("wr_data_hold", bus.wr_data, exp_wr_data);
  endtask

  initial begin
    logic [7:0] c, d;
    bit m;
    int kind;
    n_reset  = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rd_val   = 8'h00;
    exp_wr_data = 8'h00;
    exp_wv_data = 8'h00;
    tick(5);
    n_reset = 1'b1;
    tick(5);

    frame(WR, 8, 8'h5A, DLEN, 1'b1, 0, 8'h00);
    chk("lit_write_5a", bus.wr_data, 8'h5A);

    frame(RD, 8, 8'h00, DLEN, 1'b0, 0, 8'hC3);
    chk("lit_read_c3_bits", rd_bits, 8'b1100_0011);

    frame(8'h11, 8, 8'hFF, 8, 1'b0, 0, 8'h00);

    frame(WR, 8, 8'h33, 4, 1'b0, 0, 8'h00);
    chk("lit_short_keeps_5a", bus.wr_data, 8'h5A);

    // reset in the middle of a write data phase
    bus.cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) spi_bit(WR[7-i], 1'b0, "miso_cmd", m);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, "miso_quiet", m);
    n_reset = 1'b0;
    exp_wr_data = 8'h00;
    tick(3);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    tick(3);
    n_reset = 1'b1;
    tick(5);
    frame(WR, 8, 8'h0F, DLEN, 1'b1, 0, 8'h00);
    chk("lit_write_0f", bus.wr_data, 8'h0F);

`ifdef SPI_SLAVE_PARITY_EN
    frame(WR, 8, 8'h5A, 9, 1'b1, 0, 8'h00);
    frame(WR, 8, 8'h66, 9, 1'b0, 0, 8'h00);
    chk("lit_bad_parity_keeps_5a", bus.wr_data, 8'h5A);
`endif

    frame(WR, 8, 8'hA5, DLEN, ~^8'hA5, 3, 8'h00);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      d = 8'($urandom);
      case (kind)
        0: frame(WR, 8, d, DLEN,
                 ($urandom_range(0, 3) != 0) ? ~^d : ^d,
                 int'($urandom_range(0, 2)), 8'h00);
        1: frame(WR, 8, d, int'($urandom_range(0, DLEN - 1)),
                 1'b0, 0, 8'h00);
        2: frame(RD, 8, d, DLEN, 1'b0,
                 int'($urandom_range(0, 2)), 8'($urandom));
        3: frame(RD, 8, d, int'($urandom_range(0, DLEN - 1)),
                 1'b0, 0, 8'($urandom));
        4: begin
          do c = 8'($urandom); while (c == WR || c == RD);
          frame(c, 8, d, int'($urandom_range(0, 9)), 1'b0, 0, 8'h00);
        end
        default: frame(8'($urandom), int'($urandom_range(1, 7)),
                       d, 0, 1'b0, 0, 8'h00);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
